// File: rtl/ibex_pkg.sv
// Shared types for the instruction fetch bus responder.
// A response word travels through the return pipeline as one packed payload.
package ibex_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } instr_resp_t;

   localparam instr_resp_t INSTR_RESP_NONE = '{rdata: 32'h0, err: 1'b0};

endpackage

// File: rtl/ibex_instr_resp_pipe.sv
// Fixed-latency return pipeline: a response entering stage 0 leaves stage Latency-1
// exactly Latency cycles later. No back-pressure; valid and payload are both reset.
module ibex_instr_resp_pipe
   import ibex_pkg::*;
#(
   parameter int unsigned Latency = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   input  instr_resp_t resp_i,
   output logic        valid_o,
   output instr_resp_t resp_o
);

   logic [Latency-1:0] valid_q;
   instr_resp_t        resp_q [Latency];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < Latency; i++) begin
            resp_q[i] <= INSTR_RESP_NONE;
         end
      end else begin
         valid_q[0] <= valid_i;
         resp_q[0]  <= resp_i;
         for (int i = 1; i < Latency; i++) begin
            valid_q[i] <= valid_q[i-1];
            resp_q[i]  <= resp_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[Latency-1];
   assign resp_o  = resp_q[Latency-1];

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Responder end of the instruction fetch bus: word memory with a side write port,
// combinational grant with outstanding-request limit, in-order fixed-latency responses.
module ibex_instr_bus_responder
   import ibex_pkg::*;
#(
   parameter int unsigned MemWords       = 1024,
   parameter logic [31:0] BaseAddr       = 32'h0,
   parameter int unsigned Latency        = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        instr_req_i,
   input  logic [31:0]                 instr_addr_i,
   output logic                        instr_gnt_o,
   output logic                        instr_rvalid_o,
   output logic [31:0]                 instr_rdata_o,
   output logic                        instr_err_o,
   input  logic                        stall_i,
   input  logic                        mem_we_i,
   input  logic [$clog2(MemWords)-1:0] mem_waddr_i,
   input  logic [31:0]                 mem_wdata_i,
   output logic                        busy_o
);

   localparam int unsigned       AddrW     = $clog2(MemWords);
   localparam int unsigned       CntW      = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0]   MaxCnt    = CntW'(MaxOutstanding);
   localparam logic [31:0]       MemWordsW = 32'(MemWords);

   // Handshake: a request is accepted in any cycle where req and gnt are both high
   // (req need not be held); each grant yields exactly one rvalid Latency cycles later,
   // in grant order, and the requester must always accept it.

   logic [31:0]     mem_q [MemWords];
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     word;
   logic            addr_err;
   logic            pipe_valid;
   instr_resp_t     req_resp, pipe_resp;

   assign word     = (instr_addr_i - BaseAddr) >> 2;
   assign addr_err = (instr_addr_i < BaseAddr) | (word >= MemWordsW);

   assign instr_gnt_o = instr_req_i & ~stall_i & (cnt_q < MaxCnt);

   // Combinational read sees the pre-edge contents, so a same-cycle side write is not visible.
   assign req_resp.rdata = addr_err ? 32'h0 : mem_q[word[AddrW-1:0]];
   assign req_resp.err   = addr_err;

   always_ff @(posedge clk_i) begin
      if (mem_we_i) begin
         mem_q[mem_waddr_i] <= mem_wdata_i;
      end
   end

   ibex_instr_resp_pipe #(
      .Latency (Latency)
   ) u_resp_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (instr_gnt_o),
      .resp_i  (req_resp),
      .valid_o (pipe_valid),
      .resp_o  (pipe_resp)
   );

   always_comb begin
      cnt_d = cnt_q + CntW'(instr_gnt_o) - CntW'(pipe_valid);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o         = (cnt_q != '0);
   assign instr_rvalid_o = pipe_valid;
   assign instr_rdata_o  = pipe_valid ? pipe_resp.rdata : 32'h0;
   assign instr_err_o    = pipe_valid & pipe_resp.err;

   cnt_bounded_a: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MaxCnt);
   rvalid_needs_cnt_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      pipe_valid |-> (cnt_q != '0));
   cnt_next_bounded_a: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_d <= MaxCnt);

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Directed bench for the fetch bus responder: two instances (Latency 1 and 3),
// expected responses queued at grant time and popped by per-instance monitors.
module tb_ibex_instr_bus_responder;

  localparam logic [31:0] BASE_A = 32'h100;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance A: Latency 1, windowed at BASE_A
  logic        a_rst_n, a_req, a_gnt, a_rvalid, a_err, a_stall, a_we, a_busy;
  logic [31:0] a_addr, a_rdata, a_wdata;
  logic [3:0]  a_waddr;

  // instance B: Latency 3, base 0
  logic        b_rst_n, b_req, b_gnt, b_rvalid, b_err, b_stall, b_we, b_busy;
  logic [31:0] b_addr, b_rdata, b_wdata;
  logic [3:0]  b_waddr;

  ibex_instr_bus_responder #(
    .MemWords(16), .BaseAddr(BASE_A), .Latency(LAT_A), .MaxOutstanding(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(a_rst_n), .instr_req_i(a_req), .instr_addr_i(a_addr),
    .instr_gnt_o(a_gnt), .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata),
    .instr_err_o(a_err), .stall_i(a_stall), .mem_we_i(a_we), .mem_waddr_i(a_waddr),
    .mem_wdata_i(a_wdata), .busy_o(a_busy)
  );

  ibex_instr_bus_responder #(
    .MemWords(16), .BaseAddr(32'h0), .Latency(LAT_B), .MaxOutstanding(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(b_rst_n), .instr_req_i(b_req), .instr_addr_i(b_addr),
    .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata),
    .instr_err_o(b_err), .stall_i(b_stall), .mem_we_i(b_we), .mem_waddr_i(b_waddr),
    .mem_wdata_i(b_wdata), .busy_o(b_busy)
  );

  // entry: [48:33] due cycle, [32] err, [31:0] rdata
  logic [48:0] exp_a_q[$];
  logic [48:0] exp_b_q[$];
  logic [31:0] model_a [16];
  int          b_rv_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [32:0] exp_a(input logic [31:0] addr);
    logic [31:0] w;
    if (addr < BASE_A) return {1'b1, 32'h0};
    w = (addr - BASE_A) >> 2;
    if (w >= 32'd16) return {1'b1, 32'h0};
    return {1'b0, model_a[w[3:0]]};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [48:0] e;
    if (a_rst_n) begin
      if (a_rvalid) begin
        if (exp_a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_rvalid: got rdata %h err %b expected no response", a_rdata, a_err);
        end else begin
          e = exp_a_q.pop_front();
          chk("a_latency", {16'h0, cyc[15:0]}, {16'h0, e[48:33]});
          chk("a_err", {31'h0, a_err}, {31'h0, e[32]});
          chk("a_rdata", a_rdata, e[31:0]);
        end
      end else begin
        chk("a_idle_bus", a_rdata | {31'h0, a_err}, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    logic [48:0] e;
    if (b_rst_n) begin
      if (b_rvalid) begin
        b_rv_seen++;
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_rvalid: got rdata %h err %b expected no response", b_rdata, b_err);
        end else begin
          e = exp_b_q.pop_front();
          chk("b_latency", {16'h0, cyc[15:0]}, {16'h0, e[48:33]});
          chk("b_err", {31'h0, b_err}, {31'h0, e[32]});
          chk("b_rdata", b_rdata, e[31:0]);
        end
      end else begin
        chk("b_idle_bus", b_rdata | {31'h0, b_err}, 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_write(input logic [3:0] idx, input logic [31:0] data);
    a_we = 1'b1; a_waddr = idx; a_wdata = data;
    @(posedge clk); #1;
    a_we = 1'b0;
    model_a[idx] = data;
  endtask

  task automatic b_write(input logic [3:0] idx, input logic [31:0] data);
    b_we = 1'b1; b_waddr = idx; b_wdata = data;
    @(posedge clk); #1;
    b_we = 1'b0;
  endtask

  // Holds req with addr until granted; leaves req high so calls chain back-to-back.
  task automatic a_issue(input logic [31:0] addr, output int waits);
    logic done;
    done = 1'b0; waits = 0;
    a_req = 1'b1; a_addr = addr;
    while (!done) begin
      @(negedge clk);
      if (a_gnt) begin
        exp_a_q.push_back({cyc[15:0] + 16'(LAT_A), exp_a(addr)});
        done = 1'b1;
      end else if (waits >= 20) begin
        checks++; errors++;
        $display("FAIL a_grant_timeout: got no gnt expected gnt for addr %h", addr);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int k;
    int rv_base;
    logic [5:0] pat;

    a_rst_n = 1'b0; a_req = 1'b0; a_addr = '0; a_stall = 1'b0;
    a_we = 1'b0; a_waddr = '0; a_wdata = '0;
    b_rst_n = 1'b0; b_req = 1'b0; b_addr = '0; b_stall = 1'b0;
    b_we = 1'b0; b_waddr = '0; b_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("a_rst_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("a_rst_rdata", a_rdata, 32'h0);
    chk("a_rst_err", {31'h0, a_err}, 32'h0);
    chk("a_rst_busy", {31'h0, a_busy}, 32'h0);
    chk("b_rst_busy", {31'h0, b_busy}, 32'h0);
    @(posedge clk); #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    for (int i = 0; i < 16; i++) a_write(4'(i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 8; i++)  b_write(4'(i), 32'hB000_0000 + 32'(i));

    // back-to-back reads at latency 1: grant every cycle
    a_issue(BASE_A + 32'h0, w);
    for (int i = 1; i < 4; i++) begin
      a_issue(BASE_A + 32'(4 * i), w);
      chk("a_b2b_gnt_waits", 32'(w), 32'h0);
    end
    a_req = 1'b0;
    idle_cycles(3);

    // window boundaries and ignored low address bits
    a_issue(BASE_A - 32'h4, w);
    a_issue(BASE_A + 32'd64, w);
    a_issue(BASE_A + 32'h2, w);
    a_issue(BASE_A + 32'd60, w);
    a_req = 1'b0;
    idle_cycles(3);

    // stall suppresses grants; release grants in the next cycle
    a_stall = 1'b1; a_req = 1'b1; a_addr = BASE_A + 32'h8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("a_stall_gnt", {31'h0, a_gnt}, 32'h0);
      chk("a_stall_busy", {31'h0, a_busy}, 32'h0);
      @(posedge clk); #1;
    end
    a_stall = 1'b0;
    @(negedge clk);
    chk("a_release_gnt", {31'h0, a_gnt}, 32'h1);
    if (a_gnt) exp_a_q.push_back({cyc[15:0] + 16'(LAT_A), exp_a(a_addr)});
    @(posedge clk); #1;
    a_req = 1'b0;
    idle_cycles(3);

    // read-before-write on a same-cycle side write to the granted word
    a_req = 1'b1; a_addr = BASE_A + 32'h14;
    a_we = 1'b1; a_waddr = 4'd5; a_wdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("a_rbw_gnt", {31'h0, a_gnt}, 32'h1);
    if (a_gnt) exp_a_q.push_back({cyc[15:0] + 16'(LAT_A), 1'b0, 32'hA000_0005});
    @(posedge clk); #1;
    a_we = 1'b0;
    model_a[5] = 32'h5555_AAAA;
    a_issue(BASE_A + 32'h14, w);
    a_req = 1'b0;
    idle_cycles(3);

    // latency 3, two outstanding: continuous req gives 1,1,0,0,1,1
    pat = 6'b110011;
    k = 0;
    b_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_addr = 32'(4 * k);
      @(negedge clk);
      chk("b_gnt_pattern", {31'h0, b_gnt}, {31'h0, pat[5-i]});
      if (b_gnt) begin
        exp_b_q.push_back({cyc[15:0] + 16'(LAT_B), 1'b0, 32'hB000_0000 + 32'(k)});
        k++;
      end
      @(posedge clk); #1;
    end
    b_req = 1'b0;
    idle_cycles(6);

    // reset with two responses in flight drops them
    b_req = 1'b1; b_addr = 32'h8;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("b_pre_rst_gnt", {31'h0, b_gnt}, 32'h1);
      if (b_gnt) exp_b_q.push_back({cyc[15:0] + 16'(LAT_B), 1'b0, 32'hB000_0002});
      @(posedge clk); #1;
    end
    chk("b_busy_two_out", {31'h0, b_busy}, 32'h1);
    b_rst_n = 1'b0; b_req = 1'b0;
    #1;
    chk("b_rst_rvalid", {31'h0, b_rvalid}, 32'h0);
    chk("b_rst_busy", {31'h0, b_busy}, 32'h0);
    exp_b_q.delete();
    rv_base = b_rv_seen;
    idle_cycles(2);
    b_rst_n = 1'b1;
    idle_cycles(8);
    chk("b_no_resp_after_rst", 32'(b_rv_seen - rv_base), 32'h0);
    chk("b_busy_after_rst", {31'h0, b_busy}, 32'h0);

    // drain
    w = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && w < 20) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain_pending", 32'(exp_a_q.size() + exp_b_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
